clkdiv_calib_ctrl: RTL

- Drives the CALIB input of the Gowin CLKDIV primitive, which the divider wrappers otherwise tie low.
- Each CALIB pulse slips the divided-clock phase by one fast-clock period.
- The block steps the phase until a downstream word-alignment detector reports a stable match, then declares lock.
- It monitors for loss of alignment and re-searches automatically. It sits beside the video/sensor clock divider in the clocking subsystem.

---
 rtl/clk_pkg.sv | 29 ++
 rtl/clkdiv_calib_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/clk_pkg.sv
// Shared types and helpers for the CLKDIV calibration controller.
// Default timing constants match a 5:1 video/sensor divider.
package clk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    PULSE,
    SETTLE,
    LOCKED,
    FAIL
  } state_e;

  localparam int unsigned DEF_DIV_RATIO     = 5;
  localparam int unsigned DEF_PULSE_LEN     = 2;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;
  localparam int unsigned DEF_CHECK_CYCLES  = 64;
  localparam int unsigned DEF_LOSS_CYCLES   = 8;
  localparam int unsigned DEF_MAX_SWEEPS    = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int unsigned max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/clkdiv_calib_ctrl.sv
// Steps the CLKDIV phase with CALIB pulses until the word-alignment detector
// reports a stable match, then watches for loss of alignment and re-searches.
//
// state  | meaning
// IDLE   | waiting for the first start request
// CHECK  | sampling align_ok for a stable run inside a bounded window
// PULSE  | calib held high to slip the divided clock by one fast period
// SETTLE | calib low, letting the divider and detector recover
// LOCKED | aligned; counting consecutive misses
// FAIL   | every phase tried MAX_SWEEPS times without success
module clkdiv_calib_ctrl
  import clk_pkg::*;
#(
  parameter int unsigned DIV_RATIO     = DEF_DIV_RATIO,
  parameter int unsigned PULSE_LEN     = DEF_PULSE_LEN,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned CHECK_CYCLES  = DEF_CHECK_CYCLES,
  parameter int unsigned LOSS_CYCLES   = DEF_LOSS_CYCLES,
  parameter int unsigned MAX_SWEEPS    = DEF_MAX_SWEEPS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       align_ok,
  output logic       calib,
  output logic       locked,
  output logic       fail,
  output logic       busy,
  output logic [2:0] phase_idx
);

  localparam int unsigned WIN_CYCLES = 2 * CHECK_CYCLES;
  localparam int unsigned CNT_MAX    = max_u(max_u(WIN_CYCLES, SETTLE_CYCLES),
                                             max_u(PULSE_LEN, LOSS_CYCLES));
  localparam int CW = cnt_width(CNT_MAX);
  localparam int SW = cnt_width(DIV_RATIO);
  localparam int WW = cnt_width(MAX_SWEEPS);

  localparam logic [CW-1:0] CHK_LAST    = CW'(CHECK_CYCLES - 1);
  localparam logic [CW-1:0] WIN_LAST    = CW'(WIN_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] LOSS_LAST   = CW'(LOSS_CYCLES - 1);
  localparam logic [SW-1:0] STEP_WRAP   = SW'(DIV_RATIO);
  localparam logic [WW-1:0] SWEEP_MAX   = WW'(MAX_SWEEPS);
  localparam logic [2:0]    PHASE_LAST  = 3'(DIV_RATIO - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [SW-1:0] step_inc;
  logic [WW-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [2:0]    phase_q, phase_d;
  logic          calib_q, locked_q, fail_q, busy_q;
  logic          enter, pulse_go;

  always_comb begin
    state_d     = state_q;
    cyc_cnt_d   = cyc_cnt_q;
    win_cnt_d   = win_cnt_q;
    step_cnt_d  = step_cnt_q;
    sweep_cnt_d = sweep_cnt_q;
    phase_d     = phase_q;
    step_inc    = '0;
    enter       = 1'b0;
    pulse_go    = 1'b0;

    // start restarts the search from any state; the hardware phase is kept
    if (start) begin
      state_d     = CHECK;
      enter       = 1'b1;
      step_cnt_d  = '0;
      sweep_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: ;
        CHECK: begin
          win_cnt_d = win_cnt_q + CW'(1);
          if (align_ok && cyc_cnt_q == CHK_LAST) begin
            state_d = LOCKED;
            enter   = 1'b1;
          end else begin
            cyc_cnt_d = align_ok ? cyc_cnt_q + CW'(1) : '0;
            if (win_cnt_q == WIN_LAST) begin
              if (sweep_cnt_q == SWEEP_MAX) begin
                state_d = FAIL;
                enter   = 1'b1;
              end else begin
                pulse_go = 1'b1;
              end
            end
          end
        end
        PULSE: begin
          if (cyc_cnt_q == PULSE_LAST) begin
            state_d = SETTLE;
            enter   = 1'b1;
          end else begin
            cyc_cnt_d = cyc_cnt_q + CW'(1);
          end
        end
        SETTLE: begin
          if (cyc_cnt_q == SETTLE_LAST) begin
            state_d = CHECK;
            enter   = 1'b1;
          end else begin
            cyc_cnt_d = cyc_cnt_q + CW'(1);
          end
        end
        LOCKED: begin
          if (align_ok) begin
            cyc_cnt_d = '0;
          end else if (cyc_cnt_q == LOSS_LAST) begin
            step_cnt_d  = '0;
            sweep_cnt_d = '0;
            pulse_go    = 1'b1;
          end else begin
            cyc_cnt_d = cyc_cnt_q + CW'(1);
          end
        end
        FAIL: ;
        default: begin
          state_d = IDLE;
          enter   = 1'b1;
        end
      endcase
    end

    if (pulse_go) begin
      state_d  = PULSE;
      enter    = 1'b1;
      phase_d  = (phase_q == PHASE_LAST) ? 3'd0 : phase_q + 3'd1;
      step_inc = step_cnt_d + SW'(1);
      if (step_inc == STEP_WRAP) begin
        step_cnt_d  = '0;
        sweep_cnt_d = sweep_cnt_d + WW'(1);
      end else begin
        step_cnt_d = step_inc;
      end
    end

    if (enter) begin
      cyc_cnt_d = '0;
      win_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_cnt_q   <= '0;
      win_cnt_q   <= '0;
      step_cnt_q  <= '0;
      sweep_cnt_q <= '0;
      phase_q     <= 3'd0;
      calib_q     <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_cnt_q   <= cyc_cnt_d;
      win_cnt_q   <= win_cnt_d;
      step_cnt_q  <= step_cnt_d;
      sweep_cnt_q <= sweep_cnt_d;
      phase_q     <= phase_d;
      // outputs decode the next state so they line up with the state register
      calib_q     <= (state_d == PULSE);
      locked_q    <= (state_d == LOCKED);
      fail_q      <= (state_d == FAIL);
      busy_q      <= (state_d == CHECK) || (state_d == PULSE) || (state_d == SETTLE);
    end
  end

  assign calib     = calib_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign busy      = busy_q;
  assign phase_idx = phase_q;

endmodule
